// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: walks a synchronous instruction ROM and
// turns each 16-bit word into the register-file/ALU control bundle.
module instr_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [15:0]       instr_data,
    output logic [15:0]       R_en,
    output logic [3:0]        R_src,
    output logic [3:0]        R_dest,
    output logic              R_or_I,
    output logic [15:0]       imm,
    output logic [7:0]        ALU_op,
    output logic              Flag_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXECUTE} state_t;

    localparam logic [15:0] IR_NOP = 16'hE000;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [3:0]        op;
    logic              isHalt;
    logic [15:0]       decEn;
    logic              decFlag;

    assign op         = ir[15:12];
    assign isHalt     = (op == 4'hF);
    assign instr_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // pc only moves on start or when leaving EXECUTE, so the ROM address is
    // stable across FETCH and DECODE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= '0;
            ir   <= IR_NOP;
            done <= 1'b0;
        end else begin
            done <= (state == EXECUTE) && isHalt;
            case (state)
                IDLE:    if (start) pc <= '0;
                DECODE:  ir <= instr_data;
                EXECUTE: if (!isHalt) pc <= pc + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        R_en      = '0;
        Flag_en   = 1'b0;
        case (state)
            IDLE:    if (start) stateNext = FETCH;
            FETCH: begin
                busy      = 1'b1;
                stateNext = DECODE;
            end
            DECODE: begin
                busy      = 1'b1;
                stateNext = EXECUTE;
            end
            EXECUTE: begin
                busy      = 1'b1;
                R_en      = decEn;
                Flag_en   = decFlag;
                stateNext = isHalt ? IDLE : FETCH;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Mux selects come straight from IR so they hold between instructions
    // and are settled for the whole EXECUTE cycle.
    always_comb begin
        R_src   = ir[3:0];
        R_dest  = ir[11:8];
        R_or_I  = 1'b0;
        imm     = '0;
        ALU_op  = '0;
        decEn   = '0;
        decFlag = 1'b0;
        if (op == 4'h0) begin
            ALU_op  = {4'h0, ir[7:4]};
            decFlag = 1'b1;
            decEn   = (ir[7:4] == 4'hB) ? 16'h0000 : (16'h0001 << ir[11:8]);
        end else if (op <= 4'hD) begin
            R_or_I  = 1'b1;
            imm     = {{8{ir[7]}}, ir[7:0]};
            ALU_op  = {op, 4'h0};
            decFlag = 1'b1;
            decEn   = 16'h0001 << ir[11:8];
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ROM model, tiny datapath model and a scoreboard
// of expected control bundles popped at each EXECUTE.
module tb_instr_sequencer;

    typedef struct packed {
        logic [15:0] rEn;
        logic [3:0]  rSrc;
        logic [3:0]  rDest;
        logic        rOrI;
        logic [15:0] imm;
        logic [7:0]  aluOp;
        logic        flagEn;
    } ctl_t;

    typedef struct packed {
        ctl_t val;
        ctl_t msk;
    } sb_t;

    localparam ctl_t M_ALL   = '{16'hFFFF, 4'hF, 4'hF, 1'b1, 16'hFFFF, 8'hFF, 1'b1};
    localparam ctl_t M_NOIMM = '{16'hFFFF, 4'hF, 4'hF, 1'b1, 16'h0000, 8'hFF, 1'b1};
    localparam ctl_t M_EN    = '{16'hFFFF, 4'h0, 4'h0, 1'b0, 16'h0000, 8'h00, 1'b1};

    logic        clk = 1'b0;
    logic        rst;
    logic        start, startS;
    logic [7:0]  instr_addr;
    logic [15:0] romData;
    logic [15:0] R_en, imm;
    logic [3:0]  R_src, R_dest;
    logic        R_or_I, Flag_en, busy, done;
    logic [7:0]  ALU_op;

    logic [1:0]  addrS;
    logic [15:0] romS;
    logic [15:0] sEn, sImm;
    logic [3:0]  sSrc, sDest;
    logic        sOrI, sFlag, sBusy, sDone;
    logic [7:0]  sOp;

    logic [15:0] rom [256];
    logic [15:0] regs [16];
    logic [15:0] aluA, aluB, aluRes;

    sb_t q[$];
    int  nCmp = 0;
    int  nErr = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .instr_addr(instr_addr),
        .instr_data(romData), .R_en(R_en), .R_src(R_src), .R_dest(R_dest),
        .R_or_I(R_or_I), .imm(imm), .ALU_op(ALU_op), .Flag_en(Flag_en),
        .busy(busy), .done(done)
    );

    assign romS = 16'hE000;
    instr_sequencer #(.ADDR_W(2)) dutS (
        .clk(clk), .rst(rst), .start(startS), .instr_addr(addrS),
        .instr_data(romS), .R_en(sEn), .R_src(sSrc), .R_dest(sDest),
        .R_or_I(sOrI), .imm(sImm), .ALU_op(sOp), .Flag_en(sFlag),
        .busy(sBusy), .done(sDone)
    );

    always_ff @(posedge clk) romData <= rom[instr_addr];

    // Datapath model: A = R[src], B = imm or R[dest], result into one-hot R_en.
    always_comb begin
        aluA = regs[R_src];
        aluB = R_or_I ? imm : regs[R_dest];
        case (ALU_op)
            8'h01, 8'h50: aluRes = aluA + aluB;
            8'h0D:        aluRes = aluA;
            8'hD0:        aluRes = aluB;
            default:      aluRes = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++)
            if (R_en[i]) regs[i] <= aluRes;
    end

    function automatic ctl_t getObs();
        return '{R_en, R_src, R_dest, R_or_I, imm, ALU_op, Flag_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input ctl_t v, input ctl_t m);
        q.push_back('{v, m});
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic test_reset();
        ctl_t o;
        rst = 1'b0;
        #3;
        o = getObs();
        nCmp++;
        if (o !== '0) begin nErr++; $display("FAIL reset_bundle got %h want 0", o); end
        nCmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin nErr++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        nCmp++;
        if (instr_addr !== 8'h00) begin nErr++; $display("FAIL reset_addr got %h want 00", instr_addr); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        nCmp++;
        if (busy !== 1'b0) begin nErr++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_imm();
        ctl_t o; sb_t e;
        clearRom();
        rom[0] = 16'h5101;
        push('{16'h0002, 4'h1, 4'h1, 1'b1, 16'h0001, 8'h50, 1'b1}, M_ALL);
        push('0, M_EN);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nCmp++;
            if (instr_addr !== 8'(i)) begin nErr++; $display("FAIL imm_fetch_addr%0d got %h want %h", i, instr_addr, i); end
            tick(); tick();
            e = q.pop_front(); o = getObs();
            nCmp++;
            if (((o ^ e.val) & e.msk) !== '0) begin nErr++; $display("FAIL imm_exec%0d got %h want %h mask %h", i, o, e.val, e.msk); end
            tick();
        end
        nCmp++;
        if (done !== 1'b1) begin nErr++; $display("FAIL imm_done got %b want 1", done); end
    endtask

    task automatic test_reg();
        ctl_t o; sb_t e;
        clearRom();
        rom[0] = 16'h0315;
        rom[1] = 16'h02B4;
        push('{16'h0008, 4'h5, 4'h3, 1'b0, 16'h0000, 8'h01, 1'b1}, M_NOIMM);
        push('{16'h0000, 4'h4, 4'h2, 1'b0, 16'h0000, 8'h0B, 1'b1}, M_NOIMM);
        push('0, M_EN);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nCmp++;
            if (instr_addr !== 8'(i)) begin nErr++; $display("FAIL reg_fetch_addr%0d got %h want %h", i, instr_addr, i); end
            tick(); tick();
            e = q.pop_front(); o = getObs();
            nCmp++;
            if (((o ^ e.val) & e.msk) !== '0) begin nErr++; $display("FAIL reg_exec%0d got %h want %h mask %h", i, o, e.val, e.msk); end
            tick();
        end
    endtask

    task automatic test_nop_halt();
        ctl_t o; sb_t e;
        clearRom();
        rom[0] = 16'h52FF;
        rom[1] = 16'hE000;
        push('{16'h0004, 4'hF, 4'h2, 1'b1, 16'hFFFF, 8'h50, 1'b1}, M_ALL);
        push('0, M_EN);
        push('0, M_EN);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nCmp++;
            if (instr_addr !== 8'(i)) begin nErr++; $display("FAIL nh_decode_addr%0d got %h want %h", i, instr_addr, i); end
            tick();
            e = q.pop_front(); o = getObs();
            nCmp++;
            if (((o ^ e.val) & e.msk) !== '0) begin nErr++; $display("FAIL nh_exec%0d got %h want %h mask %h", i, o, e.val, e.msk); end
            tick();
        end
        nCmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin nErr++; $display("FAIL nh_done_cycle got done=%b busy=%b want 1 0", done, busy); end
        tick();
        nCmp++;
        if (done !== 1'b0) begin nErr++; $display("FAIL nh_done_width got %b want 0", done); end
        tick(); tick();
        nCmp++;
        if (busy !== 1'b0 || instr_addr !== 8'h02) begin nErr++; $display("FAIL nh_stay_idle got busy=%b addr=%h want 0 02", busy, instr_addr); end
    endtask

    task automatic test_start_busy();
        clearRom();
        rom[0] = 16'hE000; rom[1] = 16'hE000; rom[2] = 16'hE000;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            nCmp++;
            if (instr_addr !== 8'((c - 1) / 3) || busy !== 1'b1) begin
                nErr++; $display("FAIL sb_cycle%0d got addr=%h busy=%b want %h 1", c, instr_addr, busy, (c - 1) / 3);
            end
            start = (c == 4);
            tick();
            start = 1'b0;
        end
        nCmp++;
        if (done !== 1'b1) begin nErr++; $display("FAIL sb_done got %b want 1", done); end
    endtask

    task automatic test_reset_mid();
        clearRom();
        rom[0] = 16'h5101;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        nCmp++;
        if (R_en !== 16'h0002) begin nErr++; $display("FAIL rm_exec_en got %h want 0002", R_en); end
        #2 rst = 1'b0;
        #1;
        nCmp++;
        if (R_en !== 16'h0000 || Flag_en !== 1'b0) begin nErr++; $display("FAIL rm_en_drop got %h %b want 0000 0", R_en, Flag_en); end
        nCmp++;
        if (instr_addr !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            nErr++; $display("FAIL rm_state got addr=%h busy=%b done=%b want 00 0 0", instr_addr, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(); tick();
        nCmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin nErr++; $display("FAIL rm_after got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_wrap();
        startS = 1'b1; tick(); startS = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 3; c++) begin
                nCmp++;
                if (addrS !== 2'(k % 4)) begin nErr++; $display("FAIL wrap_k%0d_c%0d got %0d want %0d", k, c, addrS, k % 4); end
                tick();
            end
        end
    endtask

    task automatic test_fib();
        clearRom();
        rom[0] = 16'hD100;
        rom[1] = 16'hD201;
        for (int i = 0; i < 5; i++) begin
            rom[2 + 2 * i] = 16'h0112;
            rom[3 + 2 * i] = 16'h0211;
        end
        rom[12] = 16'hF000;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 200 && done !== 1'b1; k++) tick();
        nCmp++;
        if (done !== 1'b1) begin nErr++; $display("FAIL fib_timeout got done=%b want 1", done); end
        nCmp++;
        if (regs[2] !== 16'h0059) begin nErr++; $display("FAIL fib_result got %h want 0059", regs[2]); end
        nCmp++;
        if (regs[1] !== 16'h0037) begin nErr++; $display("FAIL fib_prev got %h want 0037", regs[1]); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; startS = 1'b0;
        clearRom();
        @(posedge clk); #1;
        test_reset();
        test_imm();
        test_reg();
        test_nop_halt();
        test_start_busy();
        test_reset_mid();
        test_wrap();
        test_fib();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode/execute control sequencer that feeds the register-file/ALU datapath. It reads 16-bit instruction words from a synchronous instruction ROM and turns each one into the datapath control bundle: register write enable, source and destination mux selects, register/immediate select, immediate value, ALU opcode and flag enable. It replaces the hard-wired Fibonacci control FSM, so any short program can run on the datapath.

## Interface
Parameters:
- ADDR_W, 8, width of program counter / instruction address; program space is 2^ADDR_W words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin executing at address 0; sampled only in IDLE.
- instr_addr  output  ADDR_W  instruction ROM address; equals pc.
- instr_data  input  16  ROM read data, valid one cycle after instr_addr is presented.
- R_en  output  16  one-hot register write enable.
- R_src  output  4  source mux select (ALU A).
- R_dest  output  4  destination mux select (ALU B via reg/imm mux).
- R_or_I  output  1  1 = ALU B takes imm, 0 = takes R_dest register.
- imm  output  16  sign-extended immediate.
- ALU_op  output  8  ALU opcode.
- Flag_en  output  1  flag register load enable.
- busy  output  1  high from FETCH through the last EXECUTE.
- done  output  1  one-cycle pulse after HALT executes.

## Operation
- Instruction fields: op = [15:12], Rdest = [11:8], ext = [7:4], Rsrc = [3:0], imm8 = [7:0].
- op 4'h0, register type: R_or_I = 0, ALU_op = {4'h0, ext}, R_src = Rsrc, R_dest = Rdest. R_en = one-hot(Rdest), except ext 4'hB (CMP), which gives R_en = 0. Flag_en = 1.
- op 4'h1..4'hD, immediate type: R_or_I = 1, imm = sign-extended imm8, ALU_op = {op, 4'h0}, R_src = Rsrc, R_dest = Rdest, R_en = one-hot(Rdest), Flag_en = 1.
- op 4'hE (NOP): R_en = 0, Flag_en = 0; pc advances.
- op 4'hF (HALT): R_en = 0, Flag_en = 0; the sequencer stops.
- States:
  - IDLE: start = 1 loads pc = 0, then goes to FETCH.
  - FETCH: goes to DECODE.
  - DECODE: IR <= instr_data, then goes to EXECUTE.
  - EXECUTE: if HALT, goes to IDLE and sets done. Otherwise pc <= pc + 1 and goes to FETCH.
- R_src, R_dest, R_or_I, imm and ALU_op are decoded from IR and hold their values between instructions, so the muxes are settled during EXECUTE.
- R_en and Flag_en are nonzero only in EXECUTE.
- start outside IDLE is ignored. start held high in IDLE restarts the program from 0.
- pc wraps from 2^ADDR_W-1 to 0 with no error; execution continues.
- Reset (any state, any time): state = IDLE, pc = 0, IR = 16'hE000 (NOP).
  - Output values under reset: R_en = 0, R_src = 0, R_dest = 0, R_or_I = 0, imm = 0, ALU_op = 0, Flag_en = 0, busy = 0, done = 0, instr_addr = 0.
  - A register write in flight is dropped. No partial instruction is retired.

## Timing
- 3 cycles per instruction: FETCH, DECODE, EXECUTE.
- The datapath register write and flag load happen on the clk edge that ends EXECUTE.
- The first FETCH is the cycle after start is sampled.
- busy rises with the first FETCH and falls in the cycle done is high.
- done is high for exactly the one cycle after HALT's EXECUTE, while in IDLE.
- instr_addr changes only on the edge that leaves EXECUTE, or on start. It is stable through FETCH and DECODE.
- Registered outputs change only on clk edges or asynchronous reset; no combinational path from instr_data to outputs.

## Test plan
- Reset, then start, with ROM[0] = 16'h5101: in cycle 3 (EXECUTE) R_en = 16'h0002, R_dest = 1, R_or_I = 1, imm = 16'h0001, ALU_op = 8'h50, Flag_en = 1; one cycle later instr_addr = 1.
- ROM[0] = 16'h0315 -> in EXECUTE R_en = 16'h0008, R_src = 5, R_dest = 3, R_or_I = 0, ALU_op = 8'h01. ROM[1] = 16'h02B4 (CMP) -> R_en = 0, Flag_en = 1, ALU_op = 8'h0B.
- ROM[0] = 16'h52FF -> imm = 16'hFFFF. ROM[1] = 16'hE000 -> R_en = 0 and Flag_en = 0. ROM[2] = 16'hF000 -> done pulses exactly 1 cycle, busy = 0, state stays IDLE with start low.
- Pulse start while busy (at cycle 4) -> pc sequence is unaffected. Assert rst low during an EXECUTE with R_en = 16'h0002 -> R_en = 0 immediately, pc = 0, busy = 0.
- ADDR_W = 2, ROM = four NOPs -> instr_addr sequence 0,1,2,3,0,1, each address held 3 cycles.
- Run a Fibonacci program on the full datapath (sequencer + register file + muxes + ALU) ending in HALT -> result register = 16'h0059 (F11 = 89) when done pulses.
